// File: rtl/fakepll7_ctrl.sv
// Power-up, lock-supervision and reconfiguration sequencer for the fakepll7 macro.
// All PLL pins and status outputs are registered from the decoded next state.
module fakepll7_ctrl #(
  parameter int NOUT    = 8,
  parameter int DIVFBW  = 16,
  parameter int RSTCYC  = 16,
  parameter int LOCKTO  = 4096,
  parameter int STABCYC = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [7:0]          cfg_divin,
  input  logic [DIVFBW-1:0]   cfg_divfb,
  input  logic [NOUT*8-1:0]   cfg_divout,
  input  logic [NOUT-1:0]     cfg_clken,
  output logic                pll_reset,
  output logic                pll_en,
  output logic                pll_bypass,
  output logic [NOUT-1:0]     pll_clken,
  output logic [7:0]          pll_divin,
  output logic [DIVFBW-1:0]   pll_divfb,
  output logic [NOUT*8-1:0]   pll_divout,
  input  logic                pll_freqlock,
  input  logic                pll_phaselock,
  output logic                locked,
  output logic                fail,
  output logic                lost_lock,
  input  logic                lost_lock_clr,
  output logic [2:0]          state
);

  localparam int RW = $clog2(RSTCYC);
  localparam int TW = $clog2(LOCKTO);
  localparam int SW = $clog2(STABCYC);

  localparam logic [RW-1:0] RST_LAST  = RW'(RSTCYC - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(LOCKTO - 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABCYC - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RST  = 3'd1,
    S_LOCK = 3'd2,
    S_STAB = 3'd3,
    S_RUN  = 3'd4,
    S_FAIL = 3'd5
  } state_t;

  state_t          state_r;
  state_t          nxt_s;
  logic            fl_meta_r;
  logic            fl_sync_r;
  logic            pl_meta_r;
  logic            pl_sync_r;
  logic            lk_s;
  logic            accept_s;
  logic            loss_s;
  logic [RW-1:0]   rst_cnt_r;
  logic [TW-1:0]   to_cnt_r;
  logic [SW-1:0]   stab_cnt_r;
  logic [NOUT-1:0] clken_r;

  assign state    = state_r;
  assign lk_s     = fl_sync_r & pl_sync_r;
  assign accept_s = cfg_valid & cfg_ready;
  // A loss only counts when the sequencer is actually going to resequence.
  assign loss_s   = start & (state_r == S_RUN) & ~lk_s;

  // Two-flop synchronisers for the asynchronous lock indicators.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fl_meta_r <= 1'b0;
      fl_sync_r <= 1'b0;
      pl_meta_r <= 1'b0;
      pl_sync_r <= 1'b0;
    end else begin
      fl_meta_r <= pll_freqlock;
      fl_sync_r <= fl_meta_r;
      pl_meta_r <= pll_phaselock;
      pl_sync_r <= pl_meta_r;
    end
  end

  // Next-state decode; dropping start overrides every other transition.
  always_comb begin
    nxt_s = state_r;
    if (!start) begin
      nxt_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: nxt_s = S_RST;
        S_RST: begin
          if (rst_cnt_r == RST_LAST) nxt_s = S_LOCK;
          else                       nxt_s = S_RST;
        end
        S_LOCK: begin
          if (lk_s)                    nxt_s = S_STAB;
          else if (to_cnt_r == TO_LAST) nxt_s = S_FAIL;
          else                         nxt_s = S_LOCK;
        end
        S_STAB: begin
          if (!lk_s)                       nxt_s = S_LOCK;
          else if (stab_cnt_r == STAB_LAST) nxt_s = S_RUN;
          else                             nxt_s = S_STAB;
        end
        S_RUN: begin
          if (!lk_s || accept_s) nxt_s = S_RST;
          else                   nxt_s = S_RUN;
        end
        S_FAIL:  nxt_s = S_FAIL;
        default: nxt_s = S_IDLE;
      endcase
    end
  end

  // Sequencer state, saturating counters, config registers and registered pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= S_IDLE;
      rst_cnt_r  <= '0;
      to_cnt_r   <= '0;
      stab_cnt_r <= '0;
      clken_r    <= '0;
      pll_divin  <= 8'd0;
      pll_divfb  <= '0;
      pll_divout <= '0;
      pll_reset  <= 1'b1;
      pll_en     <= 1'b0;
      pll_bypass <= 1'b1;
      pll_clken  <= '0;
      locked     <= 1'b0;
      fail       <= 1'b0;
      lost_lock  <= 1'b0;
      cfg_ready  <= 1'b1;
    end else begin
      state_r <= nxt_s;

      if (state_r != S_RST)          rst_cnt_r <= '0;
      else if (rst_cnt_r != RST_LAST) rst_cnt_r <= rst_cnt_r + RW'(1);

      // Timeout restarts only from RST so a chattering lock still expires.
      if (state_r == S_RST)
        to_cnt_r <= '0;
      else if ((state_r == S_LOCK || state_r == S_STAB) && to_cnt_r != TO_LAST)
        to_cnt_r <= to_cnt_r + TW'(1);

      if (state_r != S_STAB)                   stab_cnt_r <= '0;
      else if (lk_s && stab_cnt_r != STAB_LAST) stab_cnt_r <= stab_cnt_r + SW'(1);

      if (accept_s) begin
        pll_divin  <= cfg_divin;
        pll_divfb  <= cfg_divfb;
        pll_divout <= cfg_divout;
        clken_r    <= cfg_clken;
      end

      if (loss_s)             lost_lock <= 1'b1;
      else if (lost_lock_clr) lost_lock <= 1'b0;

      cfg_ready <= (nxt_s == S_IDLE) || (nxt_s == S_RUN);
      locked    <= (nxt_s == S_RUN);
      fail      <= (nxt_s == S_FAIL);

      case (nxt_s)
        S_RST: begin
          pll_reset  <= 1'b1;
          pll_en     <= 1'b1;
          pll_bypass <= 1'b1;
          pll_clken  <= '0;
        end
        S_LOCK, S_STAB: begin
          pll_reset  <= 1'b0;
          pll_en     <= 1'b1;
          pll_bypass <= 1'b1;
          pll_clken  <= '0;
        end
        S_RUN: begin
          pll_reset  <= 1'b0;
          pll_en     <= 1'b1;
          pll_bypass <= 1'b0;
          pll_clken  <= clken_r;
        end
        default: begin
          pll_reset  <= 1'b1;
          pll_en     <= 1'b0;
          pll_bypass <= 1'b1;
          pll_clken  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fakepll7_ctrl.sv
// Directed self-checking bench for fakepll7_ctrl with default parameters.
module tb_fakepll7_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_divin;
  logic [15:0] cfg_divfb;
  logic [63:0] cfg_divout;
  logic [7:0]  cfg_clken;
  logic        pll_reset;
  logic        pll_en;
  logic        pll_bypass;
  logic [7:0]  pll_clken;
  logic [7:0]  pll_divin;
  logic [15:0] pll_divfb;
  logic [63:0] pll_divout;
  logic        pll_freqlock;
  logic        pll_phaselock;
  logic        locked;
  logic        fail;
  logic        lost_lock;
  logic        lost_lock_clr;
  logic [2:0]  state;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc;

  localparam logic [2:0] IDLE = 3'd0, RST = 3'd1, LOCK = 3'd2, STAB = 3'd3, RUN = 3'd4, FAILS = 3'd5;

  fakepll7_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_divin(cfg_divin), .cfg_divfb(cfg_divfb), .cfg_divout(cfg_divout), .cfg_clken(cfg_clken),
    .pll_reset(pll_reset), .pll_en(pll_en), .pll_bypass(pll_bypass), .pll_clken(pll_clken),
    .pll_divin(pll_divin), .pll_divfb(pll_divfb), .pll_divout(pll_divout),
    .pll_freqlock(pll_freqlock), .pll_phaselock(pll_phaselock), .locked(locked), .fail(fail),
    .lost_lock(lost_lock), .lost_lock_clr(lost_lock_clr), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, output int cycles);
    cycles = 0;
    while (state !== target && cycles < budget) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; cfg_valid = 1'b0; cfg_divin = 8'd0; cfg_divfb = 16'd0;
    cfg_divout = 64'd0; cfg_clken = 8'd0; pll_freqlock = 1'b0; pll_phaselock = 1'b0; lost_lock_clr = 1'b0;
    #2;
    n_checks++; if (state !== IDLE) $display("FAIL reset_state got %0d want 0", state); else n_pass++;
    n_checks++; if (pll_reset !== 1'b1) $display("FAIL reset_pll_reset got %b want 1", pll_reset); else n_pass++;
    n_checks++; if (pll_en !== 1'b0) $display("FAIL reset_pll_en got %b want 0", pll_en); else n_pass++;
    n_checks++; if (pll_bypass !== 1'b1) $display("FAIL reset_bypass got %b want 1", pll_bypass); else n_pass++;
    n_checks++; if (pll_clken !== 8'h00) $display("FAIL reset_clken got %h want 00", pll_clken); else n_pass++;
    n_checks++; if (pll_divfb !== 16'h0000) $display("FAIL reset_divfb got %h want 0000", pll_divfb); else n_pass++;
    n_checks++; if (locked !== 1'b0 || fail !== 1'b0 || lost_lock !== 1'b0) $display("FAIL reset_status got %b%b%b want 000", locked, fail, lost_lock); else n_pass++;
    n_checks++; if (cfg_ready !== 1'b1) $display("FAIL reset_cfg_ready got %b want 1", cfg_ready); else n_pass++;
    tick(); tick();
    reset = 1'b0;
    tick();
    n_checks++; if (state !== IDLE) $display("FAIL idle_hold got %0d want 0", state); else n_pass++;
  endtask

  task automatic test_lockup();
    cfg_valid = 1'b1; cfg_divin = 8'h03; cfg_divfb = 16'h0010; cfg_divout = 64'h0102030405060708;
    cfg_clken = 8'hA5; start = 1'b1;
    tick();
    cfg_valid = 1'b0;
    n_checks++; if (state !== RST) $display("FAIL lockup_enter_rst got %0d want 1", state); else n_pass++;
    n_checks++; if (pll_divfb !== 16'h0010 || pll_divin !== 8'h03) $display("FAIL idle_cfg_load got %h/%h want 0010/03", pll_divfb, pll_divin); else n_pass++;
    n_checks++; if (pll_divout !== 64'h0102030405060708) $display("FAIL idle_divout got %h want 0102030405060708", pll_divout); else n_pass++;
    n_checks++; if (cfg_ready !== 1'b0 || pll_reset !== 1'b1 || pll_en !== 1'b1 || pll_bypass !== 1'b1) $display("FAIL rst_pins got rdy%b rst%b en%b byp%b want 0111", cfg_ready, pll_reset, pll_en, pll_bypass); else n_pass++;
    for (int i = 1; i < 16; i++) begin
      tick();
      n_checks++; if (state !== RST) $display("FAIL rst_hold cycle %0d got %0d want 1", i, state); else n_pass++;
    end
    tick();
    n_checks++; if (state !== LOCK) $display("FAIL rst_exit got %0d want 2", state); else n_pass++;
    n_checks++; if (pll_reset !== 1'b0 || pll_en !== 1'b1 || pll_bypass !== 1'b1) $display("FAIL lock_pins got rst%b en%b byp%b want 011", pll_reset, pll_en, pll_bypass); else n_pass++;
    repeat (5) tick();
    pll_freqlock = 1'b1; pll_phaselock = 1'b1;
    tick();
    n_checks++; if (state !== LOCK) $display("FAIL sync_lat1 got %0d want 2", state); else n_pass++;
    tick();
    n_checks++; if (state !== LOCK) $display("FAIL sync_lat2 got %0d want 2", state); else n_pass++;
    tick();
    n_checks++; if (state !== STAB) $display("FAIL enter_stab got %0d want 3", state); else n_pass++;
    for (int i = 1; i < 64; i++) begin
      tick();
      n_checks++; if (state !== STAB) $display("FAIL stab_hold cycle %0d got %0d want 3", i, state); else n_pass++;
    end
    tick();
    n_checks++; if (state !== RUN || locked !== 1'b1) $display("FAIL enter_run got %0d/%b want 4/1", state, locked); else n_pass++;
    n_checks++; if (pll_bypass !== 1'b0 || pll_clken !== 8'hA5) $display("FAIL run_pins got byp%b clken%h want 0/a5", pll_bypass, pll_clken); else n_pass++;
    n_checks++; if (cfg_ready !== 1'b1 || lost_lock !== 1'b0) $display("FAIL run_status got rdy%b lost%b want 1/0", cfg_ready, lost_lock); else n_pass++;
  endtask

  task automatic test_timeout();
    start = 1'b0; pll_freqlock = 1'b0; pll_phaselock = 1'b0;
    tick();
    n_checks++; if (state !== IDLE || locked !== 1'b0) $display("FAIL run_to_idle got %0d/%b want 0/0", state, locked); else n_pass++;
    tick(); tick();
    start = 1'b1;
    tick();
    repeat (15) tick();
    tick();
    n_checks++; if (state !== LOCK) $display("FAIL to_enter_lock got %0d want 2", state); else n_pass++;
    for (int i = 1; i < 4096; i++) tick();
    n_checks++; if (state !== LOCK) $display("FAIL to_last_lock got %0d want 2", state); else n_pass++;
    tick();
    n_checks++; if (state !== FAILS || fail !== 1'b1) $display("FAIL to_fail got %0d/%b want 5/1", state, fail); else n_pass++;
    n_checks++; if (pll_en !== 1'b0 || pll_reset !== 1'b1 || pll_bypass !== 1'b1 || cfg_ready !== 1'b0) $display("FAIL fail_pins got en%b rst%b byp%b rdy%b want 0110", pll_en, pll_reset, pll_bypass, cfg_ready); else n_pass++;
    repeat (3) tick();
    n_checks++; if (state !== FAILS) $display("FAIL fail_hold got %0d want 5", state); else n_pass++;
    start = 1'b0;
    tick();
    n_checks++; if (state !== IDLE || fail !== 1'b0 || cfg_ready !== 1'b1) $display("FAIL fail_exit got %0d/%b/%b want 0/0/1", state, fail, cfg_ready); else n_pass++;
  endtask

  task automatic test_glitch();
    start = 1'b1;
    tick();
    repeat (15) tick();
    tick();
    n_checks++; if (state !== LOCK) $display("FAIL gl_enter_lock got %0d want 2", state); else n_pass++;
    repeat (10) tick();
    pll_freqlock = 1'b1; pll_phaselock = 1'b1;
    tick(); tick(); tick();
    n_checks++; if (state !== STAB) $display("FAIL gl_enter_stab got %0d want 3", state); else n_pass++;
    repeat (30) tick();
    n_checks++; if (state !== STAB) $display("FAIL gl_stab30 got %0d want 3", state); else n_pass++;
    pll_phaselock = 1'b0;
    tick();
    pll_phaselock = 1'b1;
    tick();
    n_checks++; if (state !== STAB) $display("FAIL gl_pre_drop got %0d want 3", state); else n_pass++;
    tick();
    n_checks++; if (state !== LOCK) $display("FAIL gl_to_lock got %0d want 2", state); else n_pass++;
    tick();
    n_checks++; if (state !== STAB) $display("FAIL gl_back_stab got %0d want 3", state); else n_pass++;
    for (int i = 1; i < 64; i++) begin
      tick();
      n_checks++; if (state !== STAB) $display("FAIL gl_restart cycle %0d got %0d want 3", i, state); else n_pass++;
    end
    tick();
    n_checks++; if (state !== RUN) $display("FAIL gl_run got %0d want 4", state); else n_pass++;
  endtask

  task automatic test_reconfig();
    n_checks++; if (cfg_ready !== 1'b1) $display("FAIL rc_ready got %b want 1", cfg_ready); else n_pass++;
    cfg_valid = 1'b1; cfg_divin = 8'h05; cfg_divfb = 16'h0020; cfg_divout = 64'h1111111111111111; cfg_clken = 8'h0F;
    tick();
    n_checks++; if (state !== RST || locked !== 1'b0 || cfg_ready !== 1'b0) $display("FAIL rc_resequence got %0d/%b/%b want 1/0/0", state, locked, cfg_ready); else n_pass++;
    n_checks++; if (pll_divfb !== 16'h0020 || pll_divin !== 8'h05 || pll_divout !== 64'h1111111111111111) $display("FAIL rc_load got %h/%h/%h", pll_divfb, pll_divin, pll_divout); else n_pass++;
    n_checks++; if (pll_clken !== 8'h00 || pll_bypass !== 1'b1 || lost_lock !== 1'b0) $display("FAIL rc_pins got clken%h byp%b lost%b want 00/1/0", pll_clken, pll_bypass, lost_lock); else n_pass++;
    cfg_divfb = 16'h0077; cfg_clken = 8'hFF;
    tick();
    cfg_valid = 1'b0;
    n_checks++; if (pll_divfb !== 16'h0020) $display("FAIL rc_no_ready_hold got %h want 0020", pll_divfb); else n_pass++;
    wait_state(RUN, 200, cyc);
    n_checks++; if (state !== RUN) $display("FAIL rc_run got %0d want 4", state); else n_pass++;
    n_checks++; if (cyc !== 80) $display("FAIL rc_latency got %0d want 80", cyc); else n_pass++;
    n_checks++; if (pll_clken !== 8'h0F || lost_lock !== 1'b0) $display("FAIL rc_run_pins got clken%h lost%b want 0f/0", pll_clken, lost_lock); else n_pass++;
  endtask

  task automatic test_lost_lock();
    pll_freqlock = 1'b0;
    tick();
    n_checks++; if (state !== RUN) $display("FAIL ll_run1 got %0d want 4", state); else n_pass++;
    tick();
    n_checks++; if (state !== RUN) $display("FAIL ll_run2 got %0d want 4", state); else n_pass++;
    tick();
    n_checks++; if (state !== RST || lost_lock !== 1'b1) $display("FAIL ll_loss got %0d/%b want 1/1", state, lost_lock); else n_pass++;
    n_checks++; if (pll_clken !== 8'h00 || locked !== 1'b0) $display("FAIL ll_clken got %h/%b want 00/0", pll_clken, locked); else n_pass++;
    pll_freqlock = 1'b1;
    wait_state(RUN, 200, cyc);
    n_checks++; if (state !== RUN || lost_lock !== 1'b1 || pll_clken !== 8'h0F) $display("FAIL ll_relock got %0d/%b/%h want 4/1/0f", state, lost_lock, pll_clken); else n_pass++;
    lost_lock_clr = 1'b1;
    tick();
    lost_lock_clr = 1'b0;
    n_checks++; if (lost_lock !== 1'b0) $display("FAIL ll_clear got %b want 0", lost_lock); else n_pass++;
    pll_freqlock = 1'b0;
    tick(); tick();
    lost_lock_clr = 1'b1;
    tick();
    lost_lock_clr = 1'b0;
    n_checks++; if (state !== RST || lost_lock !== 1'b1) $display("FAIL ll_set_wins got %0d/%b want 1/1", state, lost_lock); else n_pass++;
    pll_freqlock = 1'b1;
    wait_state(RUN, 200, cyc);
    n_checks++; if (state !== RUN) $display("FAIL ll_relock2 got %0d want 4", state); else n_pass++;
  endtask

  task automatic test_midseq();
    pll_freqlock = 1'b0; pll_phaselock = 1'b0; start = 1'b0;
    tick();
    n_checks++; if (state !== IDLE || pll_en !== 1'b0 || pll_reset !== 1'b1) $display("FAIL ms_idle got %0d en%b rst%b want 0/0/1", state, pll_en, pll_reset); else n_pass++;
    start = 1'b1;
    tick();
    repeat (15) tick();
    tick();
    tick(); tick();
    n_checks++; if (state !== LOCK) $display("FAIL ms_lock got %0d want 2", state); else n_pass++;
    start = 1'b0;
    tick();
    n_checks++; if (state !== IDLE || pll_en !== 1'b0 || pll_reset !== 1'b1) $display("FAIL ms_abort got %0d en%b rst%b want 0/0/1", state, pll_en, pll_reset); else n_pass++;
    pll_freqlock = 1'b1; pll_phaselock = 1'b1; start = 1'b1;
    wait_state(RUN, 200, cyc);
    n_checks++; if (state !== RUN || lost_lock !== 1'b1) $display("FAIL ms_run got %0d/%b want 4/1", state, lost_lock); else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (state !== IDLE || locked !== 1'b0 || lost_lock !== 1'b0 || fail !== 1'b0) $display("FAIL ar_status got %0d/%b/%b/%b want 0/0/0/0", state, locked, lost_lock, fail); else n_pass++;
    n_checks++; if (pll_reset !== 1'b1 || pll_en !== 1'b0 || pll_bypass !== 1'b1 || pll_clken !== 8'h00) $display("FAIL ar_pins got rst%b en%b byp%b clken%h want 1/0/1/00", pll_reset, pll_en, pll_bypass, pll_clken); else n_pass++;
    n_checks++; if (pll_divfb !== 16'h0000 || pll_divin !== 8'h00 || pll_divout !== 64'h0) $display("FAIL ar_dividers got %h/%h/%h want 0", pll_divfb, pll_divin, pll_divout); else n_pass++;
    n_checks++; if (cfg_ready !== 1'b1) $display("FAIL ar_ready got %b want 1", cfg_ready); else n_pass++;
    tick();
    reset = 1'b0; start = 1'b0;
    tick();
    n_checks++; if (state !== IDLE) $display("FAIL ar_after got %0d want 0", state); else n_pass++;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lockup();
    test_timeout();
    test_glitch();
    test_reconfig();
    test_lost_lock();
    test_midseq();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
